// File: rtl/serial_accumulator_pkg.sv
// Shared definitions for the bit-serial accumulator: state encoding and
// the helper that sizes the bit counter from the accumulator width.
package serial_accumulator_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_ADD  = ADD,
    ST_DONE = DONE
  } state_t;

  // Counter must index bits 0..accWidth-1; never narrower than one bit.
  function automatic int cntWidth(input int accWidth);
    return (accWidth <= 2) ? 1 : $clog2(accWidth);
  endfunction

endpackage

// File: rtl/serial_accumulator_if.sv
// Operand handshake and result bus of the serial accumulator.
// The master supplies operands and clear; the slave (the accumulator)
// returns ready, the registered sum, its strobe and the overflow flag.
interface serial_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 clear;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_valid;
  logic                 overflow;

  modport master (
    output in_valid, in_data, clear,
    input  in_ready, acc_out, out_valid, overflow
  );

  modport slave (
    input  in_valid, in_data, clear,
    output in_ready, acc_out, out_valid, overflow
  );

endinterface

// File: rtl/serial_accumulator_full_adder.sv
// One-bit full adder; the accumulator reuses a single instance every cycle
// and closes the carry loop through its own flop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: adds one unsigned operand into a running sum,
// LSB first, one bit per clock through a single full adder. The sum is
// published with a one-cycle strobe and a sticky carry-out flag.
module serial_accumulator
  import serial_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_accumulator_if.slave   bus
);

  localparam int CNT_W = cntWidth(ACC_WIDTH);

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_accShift;
  logic [ACC_WIDTH-1:0] r_opShift;
  logic                 r_carry;
  logic                 r_overflow;
  logic                 r_outValid;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     w_inData;
  logic [ACC_WIDTH-1:0] w_accNext;
  logic                 w_sum;
  logic                 w_carryOut;
  logic                 w_lastBit;

  full_adder u_fullAdder (
    .a         (r_accShift[0]),
    .b         (r_opShift[0]),
    .carry_in  (r_carry),
    .sum       (w_sum),
    .carry_out (w_carryOut)
  );

  assign w_inData  = bus.in_data;
  assign w_accNext = {w_sum, r_accShift[ACC_WIDTH-1:1]};
  assign w_lastBit = (r_cnt == CNT_W'(ACC_WIDTH - 1));

  assign bus.in_ready  = (r_state == ST_IDLE) && !bus.clear;
  assign bus.acc_out   = r_acc;
  assign bus.out_valid = r_outValid;
  assign bus.overflow  = r_overflow;

  // FSM plus datapath: load on acceptance, rotate one sum bit per ADD cycle,
  // commit the fully rotated sum on the last bit and strobe for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_accShift <= '0;
      r_opShift  <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_outValid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_outValid <= 1'b0;
          if (bus.clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
          end else if (bus.in_valid) begin
            r_opShift  <= ACC_WIDTH'(w_inData);
            r_accShift <= r_acc;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_accShift <= w_accNext;
          r_opShift  <= {1'b0, r_opShift[ACC_WIDTH-1:1]};
          r_carry    <= w_carryOut;
          r_cnt      <= r_cnt + 1'b1;
          if (w_lastBit) begin
            r_acc      <= w_accNext;
            r_overflow <= r_overflow | w_carryOut;
            r_outValid <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_outValid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_outValid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_accumulator.sv
// Self-checking bench for serial_accumulator: a 16-bit default instance and
// a 9-bit instance for wrap/overflow. Expected sums come from plain modular
// arithmetic on integers.
module tb_serial_accumulator;

  localparam int ACC  = 16;
  localparam int ACC9 = 9;

  logic clk = 1'b0;
  logic rst;
  logic rst9;

  int checks = 0;
  int errors = 0;

  int modelAcc;
  bit modelOvf;
  int model9Acc;
  bit model9Ovf;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  serial_accumulator_if #(.WIDTH(8), .ACC_WIDTH(ACC))  bus ();
  serial_accumulator_if #(.WIDTH(8), .ACC_WIDTH(ACC9)) bus9 ();

  serial_accumulator #(.WIDTH(8), .ACC_WIDTH(ACC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_accumulator #(.WIDTH(8), .ACC_WIDTH(ACC9)) u_dut9 (
    .clk (clk),
    .rst (rst9),
    .bus (bus9)
  );

  // Reference model: unsigned add modulo 2^ACC with sticky carry-out.
  task automatic modelAdd(input int d);
    int s;
    s = modelAcc + d;
    if (s >= (1 << ACC)) modelOvf = 1'b1;
    modelAcc = s % (1 << ACC);
  endtask

  task automatic model9Add(input int d);
    int s;
    s = model9Acc + d;
    if (s >= (1 << ACC9)) model9Ovf = 1'b1;
    model9Acc = s % (1 << ACC9);
  endtask

  // Offer one operand to the 16-bit instance and observe the following
  // ACC+4 cycles; clearAt>0 pulses clear at that cycle of the operation.
  task automatic runAdd(input logic [7:0] d, input int clearAt,
                        output logic [15:0] res, output bit accepted,
                        output int readyLow, output int validCnt,
                        output int validPos);
    res = '0; readyLow = 0; validCnt = 0; validPos = 0;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1 accepted = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    for (int k = 1; k <= ACC + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (!bus.in_ready) readyLow++;
      if (bus.out_valid) begin
        validCnt++;
        validPos = k;
        res = bus.acc_out;
      end
      bus.clear   = (k == clearAt);
      bus.in_data = 8'($urandom);
    end
    bus.clear = 1'b0;
  endtask

  task automatic runAdd9(input logic [7:0] d, output logic [8:0] res,
                         output bit seen);
    res = '0; seen = 1'b0;
    @(negedge clk);
    bus9.in_valid = 1'b1;
    bus9.in_data  = d;
    @(negedge clk);
    bus9.in_valid = 1'b0;
    for (int k = 1; k <= ACC9 + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (bus9.out_valid) begin
        seen = 1'b1;
        res  = bus9.acc_out;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst9 = 1'b1;
    bus.in_valid = 1'b1;  bus.in_data = 8'($urandom);  bus.clear = 1'b0;
    bus9.in_valid = 1'b1; bus9.in_data = 8'($urandom); bus9.clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.acc_out !== 16'h0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state acc=%h valid=%b ovf=%b expected 0/0/0",
               bus.acc_out, bus.out_valid, bus.overflow);
    end
    checks++;
    if (bus9.acc_out !== 9'h0 || bus9.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state9 acc=%h ovf=%b expected 0/0", bus9.acc_out, bus9.overflow);
    end
    bus.in_valid = 1'b0; bus9.in_valid = 1'b0;
    rst = 1'b0; rst9 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc_out !== 16'h0) begin
      errors++;
      $display("[TB] FAIL ready_after_reset ready=%b valid=%b acc=%h expected 1/0/0000",
               bus.in_ready, bus.out_valid, bus.acc_out);
    end
    modelAcc = 0; modelOvf = 1'b0; model9Acc = 0; model9Ovf = 1'b0;
  endtask

  task automatic test_single_add;
    logic [15:0] res; bit acc; int rl, vc, vp;
    runAdd(8'hA5, 0, res, acc, rl, vc, vp);
    modelAdd(8'hA5);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("[TB] FAIL single_accept ready=%b expected 1", acc);
    end
    checks++;
    if (rl != ACC + 1) begin
      errors++; $display("[TB] FAIL single_ready_low got %0d cycles expected %0d", rl, ACC + 1);
    end
    checks++;
    if (vc != 1 || vp != ACC + 1) begin
      errors++; $display("[TB] FAIL single_strobe count=%0d pos=%0d expected 1 at %0d", vc, vp, ACC + 1);
    end
    checks++;
    if (res !== 16'(modelAcc)) begin
      errors++; $display("[TB] FAIL single_result got %h expected %h", res, 16'(modelAcc));
    end
  endtask

  task automatic test_back_to_back;
    int accepts[$];
    logic [15:0] results[$];
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    modelAcc = 0; modelOvf = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int n = 0; n < 3 * (ACC + 2) + 4; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.out_valid) results.push_back(bus.acc_out);
      if (bus.in_ready && bus.in_valid) accepts.push_back(n);
      if (accepts.size() == 3) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepts.size() != 3 || results.size() != 3) begin
      errors++;
      $display("[TB] FAIL b2b_counts accepts=%0d results=%0d expected 3/3", accepts.size(), results.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        modelAdd(8'hFF);
        checks++;
        if (results[i] !== 16'(modelAcc)) begin
          errors++; $display("[TB] FAIL b2b_result%0d got %h expected %h", i, results[i], 16'(modelAcc));
        end
      end
      checks++;
      if (accepts[1] - accepts[0] != ACC + 2 || accepts[2] - accepts[1] != ACC + 2) begin
        errors++;
        $display("[TB] FAIL b2b_spacing got %0d,%0d expected %0d", accepts[1] - accepts[0],
                 accepts[2] - accepts[1], ACC + 2);
      end
    end
    checks++;
    if (bus.overflow !== modelOvf) begin
      errors++; $display("[TB] FAIL b2b_overflow got %b expected %b", bus.overflow, modelOvf);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] ops [4];
    logic [8:0] res; bit seen;
    ops[0] = 8'hFF; ops[1] = 8'hFF; ops[2] = 8'hFF; ops[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      runAdd9(ops[i], res, seen);
      model9Add(ops[i]);
      checks++;
      if (!seen || res !== 9'(model9Acc) || bus9.overflow !== model9Ovf) begin
        errors++;
        $display("[TB] FAIL wrap_add%0d seen=%b acc=%h ovf=%b expected acc=%h ovf=%b", i, seen,
                 res, bus9.overflow, 9'(model9Acc), model9Ovf);
      end
    end
    @(negedge clk);
    bus9.clear = 1'b1;
    @(negedge clk);
    bus9.clear = 1'b0;
    model9Acc = 0; model9Ovf = 1'b0;
    checks++;
    if (bus9.acc_out !== 9'h0 || bus9.overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_clear acc=%h ovf=%b expected 0/0", bus9.acc_out, bus9.overflow);
    end
  endtask

  task automatic test_clear_priority;
    logic [15:0] res; bit acc; int rl, vc, vp;
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_blocks_ready got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    modelAcc = 0; modelOvf = 1'b0;
    #1;
    checks++;
    if (bus.acc_out !== 16'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_idle acc=%h valid=%b ready=%b expected 0000/0/1",
               bus.acc_out, bus.out_valid, bus.in_ready);
    end
    runAdd(8'h20, 0, res, acc, rl, vc, vp);
    modelAdd(8'h20);
    runAdd(8'h5A, 3, res, acc, rl, vc, vp);
    modelAdd(8'h5A);
    checks++;
    if (vc != 1 || res !== 16'(modelAcc)) begin
      errors++; $display("[TB] FAIL clear_in_add strobes=%0d got %h expected %h", vc, res, 16'(modelAcc));
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res; bit acc; int rl, vc, vp;
    int strobes;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    modelAcc = 0; modelOvf = 1'b0;
    runAdd(8'h10, 0, res, acc, rl, vc, vp);
    modelAdd(8'h10);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelAcc = 0; modelOvf = 1'b0;
    checks++;
    if (bus.acc_out !== 16'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid acc=%h valid=%b ready=%b expected 0000/0/1",
               bus.acc_out, bus.out_valid, bus.in_ready);
    end
    strobes = 0;
    for (int k = 0; k < ACC + 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("[TB] FAIL reset_mid_strobe got %0d strobes expected 0", strobes);
    end
    runAdd(8'h01, 0, res, acc, rl, vc, vp);
    modelAdd(8'h01);
    checks++;
    if (vc != 1 || res !== 16'(modelAcc)) begin
      errors++; $display("[TB] FAIL reset_mid_after got %h expected %h", res, 16'(modelAcc));
    end
  endtask

  task automatic test_random;
    logic [15:0] res; bit acc; int rl, vc, vp;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        modelAcc = 0; modelOvf = 1'b0;
      end
      d = 8'($urandom_range(0, 255));
      runAdd(d, 0, res, acc, rl, vc, vp);
      modelAdd(int'(d));
      checks++;
      if (vc != 1 || res !== 16'(modelAcc) || bus.overflow !== modelOvf) begin
        errors++;
        $display("[TB] FAIL random%0d op=%h strobes=%0d acc=%h ovf=%b expected %h/%b", i, d, vc,
                 res, bus.overflow, 16'(modelAcc), modelOvf);
      end
    end
  endtask

  // Bound the whole run so a stuck design cannot hang the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_overflow();
    test_clear_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
